// File: rtl/fir_coef_sequencer.sv
// Coefficient store and burst sequencer for the sparse 7-tap FIR.
// Streams one complete set per load and qualifies the filter output.
module fir_coef_sequencer #(
  parameter int NTAPS = 7,
  parameter int NSETS = 4,
  parameter int CW = 8,
  localparam int SW = $clog2(NSETS),
  localparam int IW = $clog2(NTAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_wr,
  input  logic [SW-1:0]        cfg_set,
  input  logic [IW-1:0]        cfg_idx,
  input  logic signed [CW-1:0] cfg_data,
  input  logic                 load_req,
  input  logic [SW-1:0]        load_set,
  input  logic                 err_clr,
  output logic signed [CW-1:0] coef_val,
  output logic                 writeen,
  output logic                 tlast,
  output logic                 load_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 y_valid,
  output logic [NSETS-1:0]     set_ready,
  output logic [2:0]           err
);

  localparam int CNTW = $clog2(NTAPS + 1);
  localparam logic [IW-1:0] LAST_I = IW'(NTAPS - 1);
  localparam logic [CNTW-1:0] LAST_C = CNTW'(NTAPS - 1);
  localparam logic [CNTW-1:0] END_C = CNTW'(NTAPS);
  localparam logic [CNTW-1:0] ONE_C = CNTW'(1);
  // edge at which the filter captures tap 1
  localparam logic [CNTW-1:0] TAP1_C = CNTW'(2);

  typedef enum logic [1:0] {
    IDLE, STREAM, SETTLE
  } state_t;

  logic signed [CW-1:0] mem [NSETS][NTAPS];
  logic signed [CW-1:0] shadow [NTAPS];
  logic [NTAPS-1:0] mask [NSETS];

  state_t state, state_d;
  logic [CNTW-1:0] idx, idx_d;
  logic [SW-1:0] act_set;

  logic in_range, conflict, wr_ok;
  logic start, incomplete;

  logic signed [CW-1:0] coef_d;
  logic wen_d, tlast_d, ack_d;
  logic busy_d, done_d, yv_d;
  logic [2:0] err_d;

  always_comb begin
    for (int s = 0; s < NSETS; s++) begin
      set_ready[s] = &mask[s];
    end
  end

  always_comb begin
    in_range = (cfg_data == '0)
            || (cfg_data == CW'(1))
            || (cfg_data == '1);
    conflict = cfg_wr && (state != IDLE)
            && (cfg_set == act_set);
    wr_ok = cfg_wr && in_range && !conflict
         && (cfg_idx <= LAST_I);
    start = load_req && (state == IDLE)
         && set_ready[load_set];
    incomplete = load_req && (state == IDLE)
              && !set_ready[load_set];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d = idx;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          idx_d = ONE_C;
        end
      end
      STREAM: begin
        if (idx == END_C) state_d = SETTLE;
        else idx_d = idx + ONE_C;
      end
      SETTLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coef_d = '0;
    wen_d = 1'b0;
    tlast_d = 1'b0;
    ack_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    yv_d = y_valid;
    unique case (state)
      IDLE: begin
        if (start) begin
          coef_d = mem[load_set][0];
          wen_d = 1'b1;
          tlast_d = (NTAPS == 1);
          ack_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      STREAM: begin
        busy_d = 1'b1;
        if (idx != END_C) begin
          coef_d = shadow[idx[IW-1:0]];
          wen_d = 1'b1;
          tlast_d = (idx == LAST_C);
        end
        if (idx == TAP1_C) yv_d = 1'b0;
      end
      SETTLE: begin
        done_d = 1'b1;
        yv_d = 1'b1;
      end
      default: ;
    endcase
    err_d = (err & {3{~err_clr}})
          | {conflict, incomplete, cfg_wr && !in_range};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_val <= '0;
      writeen <= 1'b0;
      tlast <= 1'b0;
      load_ack <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      y_valid <= 1'b0;
      err <= '0;
      act_set <= '0;
      for (int s = 0; s < NSETS; s++) begin
        mask[s] <= '0;
      end
    end else begin
      coef_val <= coef_d;
      writeen <= wen_d;
      tlast <= tlast_d;
      load_ack <= ack_d;
      busy <= busy_d;
      done <= done_d;
      y_valid <= yv_d;
      err <= err_d;
      if (start) act_set <= load_set;
      if (wr_ok) mask[cfg_set][cfg_idx] <= 1'b1;
    end
  end

  // snapshot keeps the burst immune to writes landing on the load edge
  always_ff @(posedge clk) begin
    if (wr_ok) mem[cfg_set][cfg_idx] <= cfg_data;
    if (start) begin
      for (int t = 0; t < NTAPS; t++) begin
        shadow[t] <= mem[load_set][t];
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Directed/random bench for fir_coef_sequencer.
// Reference keeps sets, masks and sticky errors as plain arrays.
module tb_fir_coef_sequencer;

  localparam int NTAPS = 7;
  localparam int NSETS = 4;

  logic clk = 1'b0;
  logic rst;
  logic cfg_wr;
  logic [1:0] cfg_set;
  logic [2:0] cfg_idx;
  logic signed [7:0] cfg_data;
  logic load_req;
  logic [1:0] load_set;
  logic err_clr;
  logic signed [7:0] coef_val;
  logic writeen, tlast, load_ack;
  logic busy, done, y_valid;
  logic [3:0] set_ready;
  logic [2:0] err;

  fir_coef_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_wr(cfg_wr), .cfg_set(cfg_set),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .load_req(load_req), .load_set(load_set),
    .err_clr(err_clr), .coef_val(coef_val),
    .writeen(writeen), .tlast(tlast),
    .load_ack(load_ack), .busy(busy),
    .done(done), .y_valid(y_valid),
    .set_ready(set_ready), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_mem [NSETS][NTAPS];
  logic [NTAPS-1:0] m_mask [NSETS];
  logic [2:0] m_err;
  logic m_yv;
  logic m_busy;
  int m_act;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_coef(input string tag, input int v);
    logic [7:0] e8;
    e8 = 8'(v);
    chk(tag, {24'd0, coef_val}, {24'd0, e8});
  endtask

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    for (int s = 0; s < NSETS; s++) r[s] = &m_mask[s];
    return r;
  endfunction

  function automatic void m_wr(int s, int i, int d);
    bit rng, conf;
    rng = (d >= -1) && (d <= 1);
    conf = m_busy && (s == m_act);
    if (!rng) m_err[0] = 1'b1;
    if (conf) m_err[2] = 1'b1;
    if (rng && !conf && i < NTAPS) begin
      m_mem[s][i] = d;
      m_mask[s][i] = 1'b1;
    end
  endfunction

  function automatic int rnd_coef();
    return int'($urandom_range(2)) - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int i,
                    input int d);
    cfg_wr = 1'b1;
    cfg_set = 2'(s);
    cfg_idx = 3'(i);
    cfg_data = 8'(d);
    tick();
    cfg_wr = 1'b0;
    m_wr(s, i, d);
    chk("wr_err", {29'd0, err}, {29'd0, m_err});
    chk("wr_rdy", {28'd0, set_ready},
        {28'd0, m_ready()});
  endtask

  task automatic clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = '0;
    chk("clr_err", {29'd0, err}, 32'd0);
  endtask

  // mode 1: inject conflict/accepted write/ignored load
  // mode 2: write same set on the load edge
  task automatic run_load(input int s, input int mode);
    int snap[NTAPS];
    int nv, rv;
    for (int t = 0; t < NTAPS; t++) snap[t] = m_mem[s][t];
    rv = rnd_coef();
    nv = (snap[3] == 1) ? -1 : 1;
    load_req = 1'b1;
    load_set = 2'(s);
    if (mode == 2) begin
      cfg_wr = 1'b1;
      cfg_set = 2'(s);
      cfg_idx = 3'd3;
      cfg_data = 8'(nv);
    end
    tick();
    load_req = 1'b0;
    cfg_wr = 1'b0;
    if (mode == 2) m_wr(s, 3, nv);
    m_busy = 1'b1;
    m_act = s;
    for (int k = 0; k < NTAPS; k++) begin
      if (k > 0) tick();
      if (mode == 1 && k == 3) m_wr(s, 0, -2);
      if (mode == 1 && k == 4) m_wr(3, 6, rv);
      chk("beat_wen", {31'd0, writeen}, 32'd1);
      chk_coef("beat_coef", snap[k]);
      chk("beat_tlast", {31'd0, tlast},
          {31'd0, k == NTAPS - 1});
      chk("beat_ack", {31'd0, load_ack},
          {31'd0, k == 0});
      chk("beat_busy", {31'd0, busy}, 32'd1);
      chk("beat_done", {31'd0, done}, 32'd0);
      chk("beat_yv", {31'd0, y_valid},
          {31'd0, (k >= 2) ? 1'b0 : m_yv});
      chk("beat_err", {29'd0, err}, {29'd0, m_err});
      chk("beat_rdy", {28'd0, set_ready},
          {28'd0, m_ready()});
      if (mode == 1) begin
        if (k == 2) begin
          cfg_wr = 1'b1;
          cfg_set = 2'(s);
          cfg_idx = 3'd0;
          cfg_data = -8'sd2;
        end else if (k == 3) begin
          cfg_set = 2'd3;
          cfg_idx = 3'd6;
          cfg_data = 8'(rv);
        end else if (k == 4) begin
          cfg_wr = 1'b0;
          load_req = 1'b1;
          load_set = 2'd1;
        end else if (k == 5) begin
          load_req = 1'b0;
        end
      end
    end
    m_yv = 1'b0;
    tick();
    chk("settle_wen", {31'd0, writeen}, 32'd0);
    chk("settle_tlast", {31'd0, tlast}, 32'd0);
    chk("settle_busy", {31'd0, busy}, 32'd1);
    chk("settle_done", {31'd0, done}, 32'd0);
    chk("settle_yv", {31'd0, y_valid}, 32'd0);
    tick();
    m_busy = 1'b0;
    m_yv = 1'b1;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_yv", {31'd0, y_valid}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_wen", {31'd0, writeen}, 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"},
        {22'd0, writeen, tlast, load_ack, busy,
         done, y_valid, err[2:0], coef_val == 0},
        {22'd0, 9'd0, 1'b1});
    chk({tag, "_rdy"}, {28'd0, set_ready}, 32'd0);
  endtask

  task automatic m_reset();
    for (int s = 0; s < NSETS; s++) m_mask[s] = '0;
    m_err = '0;
    m_yv = 1'b0;
    m_busy = 1'b0;
    m_act = 0;
  endtask

  initial begin
    int pat[NTAPS];
    pat = '{1, 0, -1, 0, 1, 0, -1};
    rst = 1'b1;
    cfg_wr = 1'b0;
    cfg_set = '0;
    cfg_idx = '0;
    cfg_data = '0;
    load_req = 1'b0;
    load_set = '0;
    err_clr = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    tick();

    for (int t = 0; t < NTAPS; t++) wr(0, t, pat[t]);
    chk("rdy_set0", {28'd0, set_ready}, 32'd1);
    run_load(0, 0);

    wr(1, 3, 2);
    chk("range_err", {29'd0, err}, 32'd1);
    clr();
    err_clr = 1'b1;
    wr(1, 2, -5);
    err_clr = 1'b0;
    m_err = 3'b001;
    chk("clr_vs_new", {29'd0, err}, 32'd1);
    clr();

    for (int t = 0; t < NTAPS - 1; t++)
      wr(2, t, rnd_coef());
    wr(2, 7, 1);
    load_req = 1'b1;
    load_set = 2'd2;
    tick();
    load_req = 1'b0;
    m_err[1] = 1'b1;
    chk("inc_err", {29'd0, err}, 32'd2);
    chk("inc_ack", {31'd0, load_ack}, 32'd0);
    chk("inc_wen", {31'd0, writeen}, 32'd0);
    tick();
    chk("inc_busy", {31'd0, busy}, 32'd0);
    clr();

    for (int t = 0; t < NTAPS; t++)
      wr(1, t, rnd_coef());
    for (int t = 0; t < NTAPS - 1; t++)
      wr(3, t, rnd_coef());
    run_load(0, 1);
    chk("conf_err", {29'd0, err}, 32'd5);
    chk("set3_rdy", {31'd0, set_ready[3]}, 32'd1);
    clr();

    for (int t = 0; t < NTAPS; t++) wr(1, t, 1);
    run_load(0, 0);
    run_load(1, 0);
    run_load(3, 2);
    run_load(3, 0);

    load_req = 1'b1;
    load_set = 2'd1;
    tick();
    load_req = 1'b0;
    repeat (3) tick();
    chk("mid_wen", {31'd0, writeen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk_zero("post_rst");
    for (int t = 0; t < NTAPS; t++)
      wr(0, t, rnd_coef());
    run_load(0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_coef_sequencer.md
# fir_coef_sequencer

Controller sitting in front of the 7-tap sparse (±1/0) FIR filter's coefficient port. Holds NSETS coefficient sets written by a host, range-checks them, and, on command, streams one set into the filter as an exact NTAPS-beat writeen burst terminated by tlast. Also produces y_valid, a qualifier aligned with the filter's registered y_out that marks outputs computed from a complete, consistent coefficient set.

## Interface
- NTAPS, 7, taps per set; must match the filter.
- NSETS, 4, number of stored coefficient sets.
- CW, 8, coefficient width (signed).
- clk  in  1  rising-edge clock, shared with the filter.
- rst  in  1  asynchronous, active-high reset, shared with the filter.
- cfg_wr  in  1  host write strobe.
- cfg_set  in  clog2(NSETS)  target set.
- cfg_idx  in  clog2(NTAPS)  target tap.
- cfg_data  in  CW  signed coefficient.
- load_req  in  1  request to stream set load_set into the filter.
- load_set  in  clog2(NSETS)  set to stream.
- err_clr  in  1  clears sticky errors.
- coef_val  out  CW  to filter coef_val.
- writeen  out  1  to filter writeen.
- tlast  out  1  to filter tlast.
- load_ack  out  1  one-cycle pulse: load_req accepted.
- busy  out  1  stream in progress.
- done  out  1  one-cycle pulse: new set active in filter.
- y_valid  out  1  filter y_out qualifier.
- set_ready  out  NSETS  bit s = all NTAPS taps of set s written.
- err  out  3  sticky {conflict, incomplete, range}.

## Operation
- Storage: NSETS×NTAPS×CW registers, plus an NTAPS-bit written-mask per set. Reset clears all masks; data is not reset.
- cfg_wr accepted when cfg_data ∈ {-1, 0, +1} and (state == IDLE or cfg_set ≠ active set): write data and set mask bit. cfg_idx ≥ NTAPS is ignored.
- Rejected writes:
  - cfg_data out of range → err[0].
  - cfg_set == active set while not IDLE → err[2].
- set_ready[s] = &mask[s]; combinational from the registered masks.
- FSM states:
  - IDLE: load_req with set_ready[load_set] → STREAM, idx = 0, latch active set, pulse load_ack. load_req with an incomplete set → err[1], stay IDLE. load_req outside IDLE is ignored with no error and is not queued.
  - STREAM: each cycle drive writeen = 1 and coef_val = mem[active][idx]; tlast = 1 when idx == NTAPS-1. Then idx++; after the last beat → SETTLE.
  - SETTLE: one cycle with writeen = 0 → IDLE, pulse done.
- The burst is always exactly NTAPS beats with tlast on the last beat, so the filter's internal index stays aligned and its valid flag is set every time.
- y_valid: set at the SETTLE→IDLE edge. Cleared at the edge where the filter writes tap 1 (second beat), because y_out from that edge through the tlast edge mixes old and new taps. Cleared by reset; low until the first load completes.
- err bits are sticky. err_clr clears them; a new error in the same cycle as err_clr wins (bit stays set). A cfg_wr that is both out of range and conflicting sets both bits.
- Reset mid-burst: all outputs return to reset values immediately. Filter and sequencer share rst, so both restart from index 0 consistently.

## Timing
- Reset values: coef_val = 0, writeen = 0, tlast = 0, load_ack = 0, busy = 0, done = 0, y_valid = 0, err = 0, set_ready = 0. FSM = IDLE.
- All outputs are registered except set_ready.
- load_req sampled at edge A (in IDLE):
  - load_ack high during cycle A..A+1.
  - writeen/coef_val beat k is valid after edge A+k; the filter captures it at edge A+k+1, for k = 0..NTAPS-1.
  - tlast coincides with beat NTAPS-1 (after edge A+NTAPS-1).
  - busy is high after edge A through edge A+NTAPS.
  - done and y_valid rise after edge A+NTAPS+1.
  - y_valid falls after edge A+2.
- Minimum spacing between accepted loads: NTAPS+2 cycles.
- A cfg_wr takes effect at the next edge. A write and a load accepted at the same edge use the pre-write memory contents.

## Test plan
- Reset, write set 0 = {1,0,-1,0,1,0,-1}, load set 0 → 7 writeen beats with exactly those values, tlast only on beat 7, done and y_valid at A+8. Feeding x = 10 constant then gives y_out = 0 with y_valid = 1.
- Write cfg_data = 2 to set 1 tap 3 → err = 3'b001, set_ready[1] unchanged. err_clr → err = 0. err_clr together with a new error → err[0] stays 1.
- load_req on set 2 with 6 of 7 taps written → err[1] = 1, no writeen, no load_ack.
- During a set 0 burst, cfg_wr to set 0 → rejected, err[2] = 1. cfg_wr to set 3 → accepted. A second load_req mid-burst → ignored, no load_ack.
- Back-to-back: load set 0 then set 1 (all taps +1, x = 5 constant). y_valid is low from A+2 through A+8; afterwards y_out = 35 with y_valid = 1.
- Assert rst at beat 4 → all outputs 0 immediately. Masks cleared, so set_ready = 0. After rewriting and reloading, the filter produces correct output.
